// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        HALT  = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic pipe_hold;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                         id_ex_flush: 1'b0, ex_mem_flush: 1'b0, pipe_hold: 1'b0};
    localparam hz_ctrl_t CTRL_RESET  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                         id_ex_flush: 1'b1, ex_mem_flush: 1'b1, pipe_hold: 1'b0};
    // Whole-pipeline freeze used for memory waits and the halted core.
    localparam hz_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                         id_ex_flush: 1'b0, ex_mem_flush: 1'b0, pipe_hold: 1'b1};

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating stall/flush event counters; only built with HAZARD_PERF_CNT_EN.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_inc_i,
    input  logic             flush_inc_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc_i && (stall_q != '1)) stall_d = stall_q + 1'b1;
        if (flush_inc_i && (flush_q != '1)) flush_d = flush_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule
`endif

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / branch-flush / memory-wait hazard controller for the 5-stage core.
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             mem_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             pipe_hold,
    output logic             mem_error
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int unsigned WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_error_q, mem_error_d;
    hz_ctrl_t          ctrl;
    logic              mem_wait, load_use, timeout_hit;
    logic              perf_stall, perf_flush;
    int unsigned       low_now;

    assign mem_wait = mem_req && !mem_ready;
    assign load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // Ordinal of the current low cycle, so the halt lands on the edge ending the T-th one.
    assign low_now     = (state_q == MWAIT) ? int'(wait_cnt_q) + 1 : 1;
    assign timeout_hit = (MEM_TIMEOUT != 0) && (low_now == MEM_TIMEOUT);

    always_comb begin
        ctrl        = CTRL_NORMAL;
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        perf_stall  = 1'b0;
        perf_flush  = 1'b0;
        if (reset) begin
            ctrl = CTRL_RESET;
        end else if (state_q == HALT) begin
            ctrl = CTRL_FREEZE;
        end else if (mem_wait) begin
            ctrl       = CTRL_FREEZE;
            perf_stall = 1'b1;
            if (timeout_hit) begin
                state_d     = HALT;
                wait_cnt_d  = '0;
                mem_error_d = 1'b1;
            end else begin
                state_d = MWAIT;
                if (state_q == RUN)        wait_cnt_d = WCNT_W'(1);
                else if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end else begin
            state_d    = RUN;
            wait_cnt_d = '0;
            if (mem_branch_taken) begin
                ctrl.if_id_flush  = 1'b1;
                ctrl.id_ex_flush  = 1'b1;
                ctrl.ex_mem_flush = 1'b1;
                perf_flush        = 1'b1;
            end else if (load_use) begin
                ctrl.pc_write    = 1'b0;
                ctrl.if_id_write = 1'b0;
                ctrl.id_ex_flush = 1'b1;
                perf_stall       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign if_id_write  = ctrl.if_id_write;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_flush = ctrl.ex_mem_flush;
    assign pipe_hold    = ctrl.pipe_hold;
    assign mem_error    = mem_error_q;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
        .clk         (clk),
        .reset       (reset),
        .stall_inc_i (perf_stall),
        .flush_inc_i (perf_flush),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
    );
`else
    logic unused_perf;
    assign unused_perf = perf_stall ^ perf_flush ^ (CNT_W != 0);
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed cases plus random stimulus vs a cycle model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned T  = 4;
    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, ex_mem_read, mem_branch_taken, mem_req, mem_ready;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold, mem_error;
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .ex_rd            (ex_rd),
        .ex_mem_read      (ex_mem_read),
        .mem_branch_taken (mem_branch_taken),
        .mem_req          (mem_req),
        .mem_ready        (mem_ready),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_flush     (ex_mem_flush),
        .pipe_hold        (pipe_hold),
        .mem_error        (mem_error)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: consecutive low-cycle count, halt flag, sticky error, event tallies.
    bit              m_known = 1'b0;
    bit              m_halt  = 1'b0;
    bit              m_err   = 1'b0;
    int unsigned     m_low   = 0;
    longint unsigned m_stall = 0;
    longint unsigned m_flush = 0;
    longint unsigned cnt_max = (64'd1 << CW) - 1;

    logic c_pcw, c_ifw, c_iff, c_idf, c_exf, c_hold, c_err;
    longint unsigned c_stall, c_flush;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit br, input bit mr, input bit rdy,
                        input bit lr, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd);
        bit e_pcw, e_ifw, e_iff, e_idf, e_exf, e_hold;
        reset = rst; mem_branch_taken = br; mem_req = mr; mem_ready = rdy;
        ex_mem_read = lr; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        #4;
        c_pcw = pc_write; c_ifw = if_id_write; c_iff = if_id_flush; c_idf = id_ex_flush;
        c_exf = ex_mem_flush; c_hold = pipe_hold; c_err = mem_error;
`ifdef HAZARD_PERF_CNT_EN
        c_stall = stall_cnt; c_flush = flush_cnt;
`else
        c_stall = m_stall; c_flush = m_flush;
`endif
        {e_pcw, e_ifw, e_iff, e_idf, e_exf, e_hold} = 6'b110000;
        if (m_known) begin
            chk("mem_error", c_err, m_err);
`ifdef HAZARD_PERF_CNT_EN
            chk("stall_cnt", c_stall, m_stall);
            chk("flush_cnt", c_flush, m_flush);
`endif
        end
        if (rst) begin
            {e_pcw, e_ifw, e_iff, e_idf, e_exf, e_hold} = 6'b001110;
            m_halt = 0; m_err = 0; m_low = 0; m_stall = 0; m_flush = 0; m_known = 1;
        end else if (m_halt) begin
            {e_pcw, e_ifw, e_iff, e_idf, e_exf, e_hold} = 6'b000001;
        end else if (mr && !rdy) begin
            {e_pcw, e_ifw, e_iff, e_idf, e_exf, e_hold} = 6'b000001;
            m_low++;
            if (m_stall < cnt_max) m_stall++;
            if (T != 0 && m_low == T) begin
                m_halt = 1; m_err = 1;
            end
        end else begin
            m_low = 0;
            if (br) begin
                {e_iff, e_idf, e_exf} = 3'b111;
                if (m_flush < cnt_max) m_flush++;
            end else if (lr && rd != 5'd0 && (rd == rs1 || rd == rs2)) begin
                {e_pcw, e_ifw, e_idf} = 3'b001;
                if (m_stall < cnt_max) m_stall++;
            end
        end
        chk("ctrl{pcw,ifw,iff,idf,exf,hold}", {c_pcw, c_ifw, c_iff, c_idf, c_exf, c_hold},
            {e_pcw, e_ifw, e_iff, e_idf, e_exf, e_hold});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    endtask

    initial begin
        int hold_cycles;
        longint unsigned s0, f0;
        reset = 1; ex_mem_read = 0; mem_branch_taken = 0; mem_req = 0; mem_ready = 0;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        @(posedge clk); #1;

        // Reset held two cycles.
        step(1, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
        step(1, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
        chk("rst_pc_write", c_pcw, 1'b0);
        chk("rst_flushes", {c_iff, c_idf, c_exf}, 3'b111);
        idle();
        chk("run_pc_write", c_pcw, 1'b1);
        chk("run_mem_error", c_err, 1'b0);

        // Load-use on rs2, then the same with x0 destination.
        step(0, 0, 0, 0, 1, 5'd1, 5'd5, 5'd5);
        chk("lu_stall", {c_pcw, c_ifw, c_idf}, 3'b001);
        step(0, 0, 0, 0, 1, 5'd1, 5'd0, 5'd0);
        chk("lu_x0_nostall", {c_pcw, c_idf}, 2'b10);

        // Branch beats load-use.
        f0 = c_flush;
        step(0, 1, 0, 0, 1, 5'd1, 5'd5, 5'd5);
        chk("br_flushes", {c_iff, c_idf, c_exf, c_pcw}, 4'b1111);
        idle();
`ifdef HAZARD_PERF_CNT_EN
        chk("br_flush_cnt_delta", c_flush - f0, 1);
`endif

        // Three low cycles then ready.
        s0 = c_stall;
        hold_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0, 5'd1, 5'd2, 5'd3);
            hold_cycles += int'(c_hold);
        end
        step(0, 0, 1, 1, 0, 5'd1, 5'd2, 5'd3);
        chk("mwait_hold_cycles", hold_cycles, 3);
        chk("mwait_resume", {c_pcw, c_hold}, 2'b10);
`ifdef HAZARD_PERF_CNT_EN
        chk("mwait_stall_cnt_delta", c_stall - s0, 3);
`endif

        // Timeout: four low cycles halt the core.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 5'd1, 5'd2, 5'd3);
        chk("to_err_not_yet", c_err, 1'b0);
        step(0, 0, 1, 1, 0, 5'd1, 5'd2, 5'd3);
        chk("to_halt", {c_err, c_hold, c_pcw}, 3'b110);
        step(0, 1, 0, 0, 0, 5'd1, 5'd2, 5'd3);
        chk("halt_persist", {c_hold, c_iff}, 2'b10);
        step(1, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
        idle();
        chk("halt_cleared", {c_err, c_pcw, c_hold}, 3'b010);

        // Reset during MWAIT with two low cycles counted.
        step(0, 0, 1, 0, 0, 5'd1, 5'd2, 5'd3);
        step(0, 0, 1, 0, 0, 5'd1, 5'd2, 5'd3);
        step(1, 0, 1, 0, 0, 5'd1, 5'd2, 5'd3);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 5'd1, 5'd2, 5'd3);
        step(0, 0, 1, 1, 0, 5'd1, 5'd2, 5'd3);
        chk("no_stale_wait", {c_err, c_pcw, c_hold}, 3'b010);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 40, 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
